// File: rtl/fact_ctrl.sv
// ---------------------------------------------------------------------------
// fact_ctrl
//   Control FSM for the factorial datapath. Accepts an operand from the host
//   over a ready/valid handshake and sequences the datapath init/done strobes.
//   It watches the datapath busy flag, captures the final product and returns
//   it to the host over a second ready/valid handshake, with an error flag
//   for overflow (n > MAX_N) or a stuck datapath (timeout).
//
// Parameters
//   SIZE    : operand/result width, must match the datapath
//   MAX_N   : largest operand whose factorial fits in SIZE bits
//   TIMEOUT : maximum number of cycles spent in RUN before aborting
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_valid   : host presents an operand
//   in_n       : operand n
//   in_ready   : block can accept an operand
//   out_valid  : result available
//   out_result : n!, or 0 on error
//   out_err    : overflow or timeout
//   out_ready  : host accepts the result
//   dp_n       : operand to the datapath (latched n)
//   dp_init    : one-cycle load strobe to the datapath
//   dp_done    : one-cycle strobe, datapath drives dp_result while high
//   dp_proceed : datapath busy flag (registered in the datapath)
//   dp_result  : datapath result, valid only while dp_done is high
// ---------------------------------------------------------------------------
module fact_ctrl #(
  parameter int SIZE    = 8,
  parameter int MAX_N   = 5,
  parameter int TIMEOUT = 300
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_n,
  output logic            in_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_result,
  output logic            out_err,
  input  logic            out_ready,
  output logic [SIZE-1:0] dp_n,
  output logic            dp_init,
  output logic            dp_done,
  input  logic            dp_proceed,
  input  logic [SIZE-1:0] dp_result
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FLUSH   = 3'd0,
    IDLE    = 3'd1,
    INIT    = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5,
    OUT     = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   n_q, n_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              to_q, to_d;
  logic [SIZE-1:0]   out_result_q, out_result_d;
  logic              out_err_q, out_err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              dp_init_q, dp_init_d;
  logic              dp_done_q, dp_done_d;

  // All outputs are registered so that reset forces every strobe low at the
  // reset edge, independent of which state the FSM lands in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FLUSH;
      n_q          <= '0;
      wcnt_q       <= '0;
      to_q         <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      dp_init_q    <= 1'b0;
      dp_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wcnt_q       <= wcnt_d;
      to_q         <= to_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      dp_init_q    <= dp_init_d;
      dp_done_q    <= dp_done_d;
    end
  end

  // Next-state logic, plus the operand latch, RUN wait counter and the
  // timeout flag that tells DONE not to overwrite the error result.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    to_d    = to_q;
    unique case (state_q)
      FLUSH: begin
        // First FLUSH cycle raises dp_done; the second one moves on.
        if (dp_done_q) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          n_d  = in_n;
          to_d = 1'b0;
          if (in_n > SIZE'(MAX_N))   state_d = OUT;
          else if (in_n <= SIZE'(1)) state_d = OUT;
          else                       state_d = INIT;
        end
      end
      INIT: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
      RUN: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        // The busy flag is ignored for two cycles: it may still show the
        // value it had before the init strobe reached the datapath.
        if (!dp_proceed && (wcnt_q >= WCNT_W'(2))) begin
          state_d = CAPTURE;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = DONE;
        end
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = OUT;
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  // Output logic: strobes decode the upcoming state so they line up with the
  // state register; result and error are loaded only at the points where a
  // job's outcome becomes known.
  always_comb begin
    in_ready_d   = (state_d == IDLE);
    out_valid_d  = (state_d == OUT);
    dp_init_d    = (state_d == INIT);
    dp_done_d    = (state_d == DONE) || ((state_q == FLUSH) && !dp_done_q);
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    if ((state_q == IDLE) && in_valid) begin
      if (in_n > SIZE'(MAX_N)) begin
        out_result_d = '0;
        out_err_d    = 1'b1;
      end else if (in_n <= SIZE'(1)) begin
        out_result_d = SIZE'(1);
        out_err_d    = 1'b0;
      end
    end else if ((state_q == RUN) && (state_d == DONE)) begin
      out_result_d = '0;
      out_err_d    = 1'b1;
    end else if ((state_q == DONE) && !to_q) begin
      out_result_d = dp_result;
      out_err_d    = 1'b0;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign dp_n       = n_q;
  assign dp_init    = dp_init_q;
  assign dp_done    = dp_done_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fact_ctrl
//   Self-checking bench for fact_ctrl. Contains a behavioural factorial
//   datapath (with an optional stuck busy flag) and a plain arithmetic
//   reference for n!. Directed jobs cover reset, small and overflow
//   operands, back-pressure, timeout and reset mid-job; a randomized loop
//   follows.
// ---------------------------------------------------------------------------
module tb_fact_ctrl;

  localparam int SIZE    = 8;
  localparam int MAX_N   = 5;
  localparam int TIMEOUT = 300;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [SIZE-1:0] in_n;
  logic            in_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_result;
  logic            out_err;
  logic            out_ready;
  logic [SIZE-1:0] dp_n;
  logic            dp_init;
  logic            dp_done;
  logic            dp_proceed;
  logic [SIZE-1:0] dp_result;

  int checks = 0;
  int errors = 0;

  // Monitor counters, updated at the falling edge.
  int initCnt    = 0;
  int doneCnt    = 0;
  int overlapCnt = 0;

  // Behavioural datapath state.
  logic            stuck = 1'b0;
  logic            mdlProceed = 1'b0;
  logic [SIZE-1:0] mdlAcc = '0;
  logic [SIZE-1:0] mdlCnt = '0;
  logic [SIZE-1:0] noise = '0;

  fact_ctrl #(.SIZE(SIZE), .MAX_N(MAX_N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_n       (in_n),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .dp_n       (dp_n),
    .dp_init    (dp_init),
    .dp_done    (dp_done),
    .dp_proceed (dp_proceed),
    .dp_result  (dp_result)
  );

  always #5 clk = ~clk;

  // Factorial datapath: loads on init, multiplies down to 1 while busy,
  // drives its product only while done is high (garbage otherwise).
  always @(posedge clk) begin
    if (!rst_n || dp_done) begin
      mdlProceed <= 1'b0;
    end else if (dp_init) begin
      mdlAcc     <= 1;
      mdlCnt     <= dp_n;
      mdlProceed <= 1'b1;
    end else if (mdlProceed) begin
      if (mdlCnt <= 1) begin
        mdlProceed <= 1'b0;
      end else begin
        mdlAcc <= mdlAcc * mdlCnt;
        mdlCnt <= mdlCnt - 1;
      end
    end
  end

  assign dp_proceed = stuck ? 1'b1 : mdlProceed;
  assign dp_result  = dp_done ? mdlAcc : noise;

  always @(negedge clk) begin
    if (dp_init) initCnt++;
    if (dp_done) doneCnt++;
    if (dp_init && dp_done) overlapCnt++;
    noise <= SIZE'($urandom);
  end

  // Reference: n! with plain arithmetic, error for n beyond MAX_N.
  function automatic void refFact(input logic [SIZE-1:0] n,
                                  output logic [SIZE-1:0] r, output logic e);
    int p;
    if (int'(n) > MAX_N) begin
      r = '0;
      e = 1'b1;
    end else begin
      p = 1;
      for (int k = 2; k <= int'(n); k++) p = p * k;
      r = p[SIZE-1:0];
      e = 1'b0;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [SIZE-1:0] n,
                               input logic ordy);
    in_valid  = v;
    in_n      = n;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // One complete job: accept n, wait (bounded) for the result, hold the
  // result under back-pressure for 'hold' cycles, then hand it off.
  task automatic runJob(input logic [SIZE-1:0] n, input int hold,
                        input logic expTimeout);
    int lat, bound, doneLat, initStart, doneStart;
    logic useDp;
    logic [SIZE-1:0] expRes;
    logic expErr;
    refFact(n, expRes, expErr);
    useDp = (int'(n) >= 2) && (int'(n) <= MAX_N);
    if (expTimeout) begin
      expRes = '0;
      expErr = 1'b1;
    end
    bound = expTimeout ? TIMEOUT + 10 : (useDp ? int'(n) + 8 : 1);
    checkOutput("in_ready_before_job", in_ready, 1);
    initStart = initCnt;
    doneStart = doneCnt;
    applyStimulus(1'b1, n, 1'b0);
    tick();
    applyStimulus(1'b0, SIZE'($urandom), 1'b0);
    lat = 1;
    doneLat = 0;
    while (!out_valid && lat < bound) begin
      if (dp_done && doneLat == 0) doneLat = lat;
      tick();
      lat++;
    end
    checkOutput("out_valid_within_bound", out_valid, 1);
    checkOutput("out_result", out_result, expRes);
    checkOutput("out_err", out_err, expErr);
    checkOutput("dp_n_latched", dp_n, n);
    checkOutput("dp_init_pulses", initCnt - initStart, useDp ? 1 : 0);
    checkOutput("dp_done_pulses", doneCnt - doneStart, useDp ? 1 : 0);
    if (expTimeout) checkOutput("timeout_done_cycle", doneLat, TIMEOUT + 2);
    for (int i = 0; i < hold; i++) begin
      applyStimulus(1'b1, SIZE'($urandom), 1'b0);
      tick();
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_out_result", out_result, expRes);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("after_handshake_out_valid", out_valid, 0);
    checkOutput("after_handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    int startDone, firstReady, ovSeen;
    rst_n = 1'b0;
    // This operand arrives together with reset and must be dropped.
    applyStimulus(1'b1, 8'd3, 1'b0);
    tick(); tick(); tick();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_dp_init", dp_init, 0);
    checkOutput("reset_dp_done", dp_done, 0);
    checkOutput("reset_dp_n", dp_n, 0);
    checkOutput("reset_out_result", out_result, 0);

    // Release reset: one flush pulse, then in_ready the cycle after.
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    startDone  = doneCnt;
    firstReady = 0;
    ovSeen     = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (out_valid) ovSeen++;
      if (in_ready && firstReady == 0) firstReady = c;
    end
    checkOutput("flush_done_pulses", doneCnt - startDone, 1);
    checkOutput("flush_first_ready_cycle", firstReady, 2);
    checkOutput("flush_no_out_valid", ovSeen, 0);

    // Directed jobs.
    runJob(8'd5, 0, 1'b0);
    runJob(8'd3, 0, 1'b0);
    runJob(8'd2, 1, 1'b0);
    runJob(8'd0, 0, 1'b0);
    runJob(8'd1, 0, 1'b0);
    runJob(8'd6, 0, 1'b0);
    runJob(8'd255, 0, 1'b0);
    runJob(8'd4, 10, 1'b0);

    // out_ready asserted while idle does nothing.
    applyStimulus(1'b0, '0, 1'b1);
    tick(); tick();
    checkOutput("idle_out_ready_in_ready", in_ready, 1);
    checkOutput("idle_out_ready_out_valid", out_valid, 0);
    applyStimulus(1'b0, '0, 1'b0);

    // Timeout with a stuck busy flag.
    stuck = 1'b1;
    runJob(8'd3, 0, 1'b1);
    stuck = 1'b0;

    // Reset during RUN of n=5.
    applyStimulus(1'b1, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'd2, 1'b0);
    tick();
    checkOutput("midreset_dp_init", dp_init, 0);
    checkOutput("midreset_dp_done", dp_done, 0);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    startDone = doneCnt;
    ovSeen    = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (out_valid) ovSeen++;
    end
    checkOutput("midreset_flush_pulses", doneCnt - startDone, 1);
    checkOutput("midreset_no_result", ovSeen, 0);
    runJob(8'd5, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      runJob(SIZE'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
      end
    end

    checkOutput("init_done_never_overlap", overlapCnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case something stalls outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog: observed stall expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
